// File: rtl/serial_link_pkg.sv
// Shared definitions for the 4-port serial link: FSM encoding, line levels,
// default field widths, the 7-segment lookup and a parity helper.
package serial_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_PORT   = 3'd2,
      ST_COUNT  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5
   } state_t;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;

   localparam int DEF_PORT_W = 32'd2;
   localparam int DEF_CNT_W  = 32'd4;

   // Active-high segments {g,f,e,d,c,b,a}, hex digits 0..F
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      return SEG_LUT[v];
   endfunction

   function automatic logic even_parity(input logic [31:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/serial_port_tx_shr.sv
// Payload shift register plus remaining-bit down counter for the frame's DATA phase.
// cur_bit is always the next payload bit to put on the line; last_bit means none remain.
module tx_payload_shr
   import serial_link_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 shift,
   input  logic [CNT_W-1:0]     n,
   input  logic [2**CNT_W-2:0]  din,
   output logic                 cur_bit,
   output logic                 last_bit,
   output logic [CNT_W-1:0]     count
);

   logic [2**CNT_W-2:0] shr_r;
   logic [CNT_W-1:0]    cnt_r;

   // Load the frame's payload and length, then consume one bit per shift
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shr_r <= '0;
         cnt_r <= '0;
      end else if (load) begin
         shr_r <= din;
         cnt_r <= n;
      end else if (shift) begin
         shr_r <= shr_r >> 1;
         cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign cur_bit  = shr_r[0];
   assign last_bit = (cnt_r == '0);
   assign count    = cnt_r;

endmodule

// File: rtl/serial_port_tx.sv
// Transmit framer: start bit, port number, payload length, then N payload bits, one per clkEn.
// Optional macro TX_PARITY_EN appends one even-parity bit before the return to idle.
module serial_port_tx
   import serial_link_pkg::*;
#(
   parameter int PORT_W = DEF_PORT_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clkEn,
   input  logic                 start,
   input  logic [PORT_W-1:0]    portNum,
   input  logic [CNT_W-1:0]     dataNum,
   input  logic [2**CNT_W-2:0]  payload,
   output logic                 serOut,
   output logic                 busy,
   output logic                 done,
   output logic [6:0]           SSDout
);

   state_t              state_r;
   logic [PORT_W-1:0]   port_r;
   logic [CNT_W-1:0]    dn_r;
   logic [CNT_W-1:0]    cnt_hdr_r;
   logic [7:0]          bidx_r;
   logic                ser_r;
   logic                busy_r;
   logic                done_r;
   logic [6:0]          ssd_r;

   logic                load_s;
   logic                shift_s;
   logic                shr_bit_s;
   logic                shr_last_s;
   logic [CNT_W-1:0]    shr_cnt_s;

`ifdef TX_PARITY_EN
   logic [2**CNT_W-2:0] masked_s;
   logic                par_r;

   // Only the N payload bits actually sent take part in the parity
   always_comb begin
      masked_s = '0;
      for (int i = 0; i < 2**CNT_W-1; i++) begin
         if (i < int'(dataNum)) begin
            masked_s[i] = payload[i];
         end else begin
            masked_s[i] = 1'b0;
         end
      end
   end
`endif

   // Shift-register control: load at accept, shift on each payload bit put on the line
   always_comb begin
      load_s  = 1'b0;
      shift_s = 1'b0;
      if (clkEn) begin
         case (state_r)
            ST_IDLE:  load_s  = start;
            ST_COUNT: shift_s = (bidx_r == 8'd0) && (dn_r != '0);
            ST_DATA:  shift_s = ~shr_last_s;
            default: begin
               load_s  = 1'b0;
               shift_s = 1'b0;
            end
         endcase
      end else begin
         load_s  = 1'b0;
         shift_s = 1'b0;
      end
   end

   tx_payload_shr #(.CNT_W(CNT_W)) u_shr (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s),
      .shift    (shift_s),
      .n        (dataNum),
      .din      (payload),
      .cur_bit  (shr_bit_s),
      .last_bit (shr_last_s),
      .count    (shr_cnt_s)
   );

   // Frame sequencer; every line/status change is registered here
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         port_r    <= '0;
         dn_r      <= '0;
         cnt_hdr_r <= '0;
         bidx_r    <= 8'd0;
         ser_r     <= LINE_IDLE;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         ssd_r     <= seg_of(4'd0);
`ifdef TX_PARITY_EN
         par_r     <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         if (clkEn) begin
            case (state_r)
               ST_IDLE: begin
                  ser_r <= LINE_IDLE;
                  if (start) begin
                     port_r    <= portNum;
                     dn_r      <= dataNum;
                     cnt_hdr_r <= dataNum;
`ifdef TX_PARITY_EN
                     par_r     <= even_parity(32'(portNum)) ^ even_parity(32'(dataNum))
                                  ^ even_parity(32'(masked_s));
`endif
                     ser_r     <= LINE_START;
                     busy_r    <= 1'b1;
                     state_r   <= ST_START;
                  end
               end
               ST_START: begin
                  ser_r   <= port_r[PORT_W-1];
                  port_r  <= port_r << 1;
                  bidx_r  <= 8'(PORT_W - 1);
                  state_r <= ST_PORT;
               end
               ST_PORT: begin
                  if (bidx_r == 8'd0) begin
                     ser_r     <= cnt_hdr_r[CNT_W-1];
                     cnt_hdr_r <= cnt_hdr_r << 1;
                     bidx_r    <= 8'(CNT_W - 1);
                     state_r   <= ST_COUNT;
                  end else begin
                     ser_r  <= port_r[PORT_W-1];
                     port_r <= port_r << 1;
                     bidx_r <= bidx_r - 8'd1;
                  end
               end
               ST_COUNT: begin
                  if (bidx_r == 8'd0) begin
                     if (dn_r != '0) begin
                        ser_r   <= shr_bit_s;
                        ssd_r   <= seg_of(4'(dn_r));
                        state_r <= ST_DATA;
                     end else begin
`ifdef TX_PARITY_EN
                        ser_r   <= par_r;
                        state_r <= ST_PARITY;
`else
                        ser_r   <= LINE_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
`endif
                     end
                  end else begin
                     ser_r     <= cnt_hdr_r[CNT_W-1];
                     cnt_hdr_r <= cnt_hdr_r << 1;
                     bidx_r    <= bidx_r - 8'd1;
                  end
               end
               ST_DATA: begin
                  // shr count is the bits still queued behind the one now on the line
                  if (shr_last_s) begin
                     ssd_r   <= seg_of(4'd0);
`ifdef TX_PARITY_EN
                     ser_r   <= par_r;
                     state_r <= ST_PARITY;
`else
                     ser_r   <= LINE_IDLE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= ST_IDLE;
`endif
                  end else begin
                     ser_r <= shr_bit_s;
                     ssd_r <= seg_of(4'(shr_cnt_s));
                  end
               end
               ST_PARITY: begin
                  ser_r   <= LINE_IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end
               default: begin
                  ser_r   <= LINE_IDLE;
                  busy_r  <= 1'b0;
                  ssd_r   <= seg_of(4'd0);
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign serOut = ser_r;
   assign busy   = busy_r;
   assign done   = done_r;
   assign SSDout = ssd_r;

endmodule

// File: tb/tb_serial_port_tx.sv
// Bench for serial_port_tx: directed frame table, start-hold, mid-frame reset and
// randomized frames checked against a frame-building reference model.
module tb_serial_port_tx;

   localparam int PW = 2;
   localparam int CW = 4;
   localparam logic [6:0] SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        clkEn   = 1'b0;
   logic        start   = 1'b0;
   logic [1:0]  portNum = 2'd0;
   logic [3:0]  dataNum = 4'd0;
   logic [14:0] payload = 15'd0;
   logic        serOut;
   logic        busy;
   logic        done;
   logic [6:0]  SSDout;

   int n_chk  = 0;
   int n_pass = 0;
   int div    = 4;
   int done_pulses = 0;
   bit exp_q[$];

   typedef struct {
      string       name;
      logic [1:0]  port;
      logic [3:0]  dn;
      logic [14:0] pl;
      logic [21:0] bits;   // frame bits, first-sent bit leftmost
      int          len;
      logic        par;
   } vec_t;
   vec_t vecs[5];

   serial_port_tx dut (
      .clk     (clk),
      .rst     (rst),
      .clkEn   (clkEn),
      .start   (start),
      .portNum (portNum),
      .dataNum (dataNum),
      .payload (payload),
      .serOut  (serOut),
      .busy    (busy),
      .done    (done),
      .SSDout  (SSDout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done === 1'b1) done_pulses++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // One bit time: exactly one rising edge with clkEn=1; returns on the following negedge
   task automatic bit_time();
      clkEn = 1'b0;
      repeat (div - 1) @(negedge clk);
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
   endtask

   // Reference: frame as a plain list of bits built from the field rules
   task automatic model_frame(input logic [1:0] p, input logic [3:0] n, input logic [14:0] pl);
      int ones;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = PW - 1; i >= 0; i--) exp_q.push_back(p[i]);
      for (int i = CW - 1; i >= 0; i--) exp_q.push_back(n[i]);
      for (int k = 0; k < int'(n); k++) exp_q.push_back(pl[k]);
      ones = 0;
      foreach (exp_q[i]) ones += int'(exp_q[i]);
`ifdef TX_PARITY_EN
      exp_q.push_back(1'(ones % 2));
`endif
   endtask

   task automatic table_frame(input vec_t v);
      exp_q.delete();
      for (int i = 0; i < v.len; i++) exp_q.push_back(v.bits[v.len - 1 - i]);
`ifdef TX_PARITY_EN
      exp_q.push_back(v.par);
`endif
   endtask

   task automatic run_frame(input string nm, input logic [1:0] p, input logic [3:0] n,
                            input logic [14:0] pl, input bit hold,
                            input logic [1:0] np, input logic [3:0] nn, input logic [14:0] npl);
      int hdr;
      int base_p;
      int exp_ssd;
      hdr = 1 + PW + CW;
      portNum = p; dataNum = n; payload = pl; start = 1'b1;
      base_p = done_pulses;
      bit_time();
      if (hold) begin
         portNum = np; dataNum = nn; payload = npl;
      end else begin
         start = 1'($urandom); portNum = 2'($urandom); dataNum = 4'($urandom); payload = 15'($urandom);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) bit_time();
         check($sformatf("%s serOut bit %0d", nm, i), 32'(serOut), 32'(exp_q[i]));
         check($sformatf("%s busy bit %0d", nm, i), 32'(busy), 32'd1);
         exp_ssd = (i < hdr || i >= hdr + int'(n)) ? 0 : int'(n) - (i - hdr);
         check($sformatf("%s SSD bit %0d", nm, i), 32'(SSDout), 32'(SEG[exp_ssd]));
         if (!hold) start = 1'($urandom);
      end
      bit_time();
      check({nm, " end serOut"}, 32'(serOut), 32'd1);
      check({nm, " end busy"}, 32'(busy), 32'd0);
      check({nm, " end done"}, 32'(done), 32'd1);
      check({nm, " end SSD"}, 32'(SSDout), 32'(SEG[0]));
      if (!hold) start = 1'b0;
      @(negedge clk);
      check({nm, " done cleared"}, 32'(done), 32'd0);
      check({nm, " done count"}, 32'(done_pulses - base_p), 32'd1);
   endtask

   initial begin
      logic [1:0]  rp;
      logic [3:0]  rn;
      logic [14:0] rpl;
      int          base_p;

      vecs[0] = '{"case1",   2'b10, 4'd3,  15'h7FF5, 22'b0100011101, 10, 1'b1};
      vecs[1] = '{"n0",      2'b01, 4'd0,  15'h1234, 22'b0010000, 7, 1'b1};
      vecs[2] = '{"n15",     2'b11, 4'd15, 15'h7FFF, 22'h1FFFFF, 22, 1'b1};
      vecs[3] = '{"n1",      2'b00, 4'd1,  15'h0001, 22'b00000011, 8, 1'b0};
      vecs[4] = '{"n5",      2'b01, 4'd5,  15'h7FF6, 22'b001010101101, 12, 1'b0};

      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset serOut", 32'(serOut), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset SSD", 32'(SSDout), 32'(SEG[0]));
      rst = 1'b1;
      @(negedge clk);

      // start without clkEn must not launch a frame
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      bit_time();
      check("start no clkEn busy", 32'(busy), 32'd0);
      check("start no clkEn serOut", 32'(serOut), 32'd1);

      for (int t = 0; t < 5; t++) begin
         table_frame(vecs[t]);
         run_frame(vecs[t].name, vecs[t].port, vecs[t].dn, vecs[t].pl, 1'b0, 2'd0, 4'd0, 15'd0);
         bit_time();
      end

      // start held across two frames; second fields appear only after the first accept
      model_frame(2'b10, 4'd2, 15'h0002);
      run_frame("hold A", 2'b10, 4'd2, 15'h0002, 1'b1, 2'b01, 4'd4, 15'h000B);
      model_frame(2'b01, 4'd4, 15'h000B);
      run_frame("hold B", 2'b01, 4'd4, 15'h000B, 1'b0, 2'd0, 4'd0, 15'd0);
      bit_time();

      // reset in the middle of DATA
      portNum = 2'b11; dataNum = 4'd8; payload = 15'h00A5; start = 1'b1;
      bit_time();
      start = 1'b0;
      repeat (1 + PW + CW + 3) bit_time();
      check("midreset pre busy", 32'(busy), 32'd1);
      base_p = done_pulses;
      rst = 1'b0;
      #1;
      check("midreset serOut", 32'(serOut), 32'd1);
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset SSD", 32'(SSDout), 32'(SEG[0]));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midreset no done", 32'(done_pulses - base_p), 32'd0);
      table_frame(vecs[0]);
      run_frame("after reset", vecs[0].port, vecs[0].dn, vecs[0].pl, 1'b0, 2'd0, 4'd0, 15'd0);
      bit_time();

      for (int r = 0; r < 25; r++) begin
         div = int'($urandom_range(5, 1));
         rp  = 2'($urandom);
         rn  = 4'($urandom);
         rpl = 15'($urandom);
         model_frame(rp, rn, rpl);
         run_frame($sformatf("rand%0d", r), rp, rn, rpl, 1'b0, 2'd0, 4'd0, 15'd0);
         if ($urandom_range(1, 0) == 1) bit_time();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
